// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline package: skid-stage state encoding and payload field layout.
// Stages pack/unpack the default PAYLOAD_W vector using these offsets.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_FULL  = ST_FULL
    } state_t;

    localparam int WORD_W     = 32;
    localparam int REGIDX_W   = 5;
    localparam int CTRL_W     = 23;
    localparam int NUM_WORDS  = 6;
    localparam int NUM_REGIDX = 3;

    // Layout, LSB first: six words, three register indices, control, lock.
    localparam int WORDS_LSB  = 0;
    localparam int REGIDX_LSB = WORDS_LSB + NUM_WORDS * WORD_W;
    localparam int CTRL_LSB   = REGIDX_LSB + NUM_REGIDX * REGIDX_W;
    localparam int LOCK_BIT   = CTRL_LSB + CTRL_W;

    localparam int PAYLOAD_W_DEF = LOCK_BIT + 1;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready bundle between two pipeline stages.
// slave: the stage itself; master: the surrounding upstream/downstream logic.
interface pipe_stage_skid_if #(
    parameter int PAYLOAD_W = 231
);

    logic                 in_valid;
    logic [PAYLOAD_W-1:0] in_data;
    logic                 out_ready;
    logic                 out_valid;
    logic [PAYLOAD_W-1:0] out_data;
    logic                 in_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_ready,
        output out_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output in_ready,
        input  out_ready,
        input  out_valid,
        input  out_data
    );

endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage register with a 2-entry skid buffer, flush and freeze.
// Ports: in_CLK, in_CLR (sync high), in_EN, in_flush, bus (slave), out_occupancy.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W     = PAYLOAD_W_DEF,
    parameter bit ZERO_ON_EMPTY = 1'b1
) (
    input  logic                    in_CLK,
    input  logic                    in_CLR,
    input  logic                    in_EN,
    input  logic                    in_flush,
    pipe_stage_skid_if.slave        bus,
    output logic [1:0]              out_occupancy
);

    state_t               state;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] skid_q;
    logic                 valid_q;
    logic                 ready_q;
    logic                 acc;
    logic                 pop;

    // Ready and valid are registered, so the handshakes see no
    // combinational dependence on the opposite side.
    assign acc = bus.in_valid & ready_q & in_EN;
    assign pop = valid_q & bus.in_ready & in_EN;

    always_ff @(posedge in_CLK) begin
        if (in_CLR) begin
            state   <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else if (in_flush) begin
            state   <= S_EMPTY;
            if (ZERO_ON_EMPTY) main_q <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            unique case (state)
                S_EMPTY: begin
                    if (acc) begin
                        state   <= S_ONE;
                        main_q  <= bus.in_data;
                        valid_q <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (acc && pop) begin
                        main_q <= bus.in_data;
                    end else if (acc) begin
                        state   <= S_FULL;
                        skid_q  <= bus.in_data;
                        ready_q <= 1'b0;
                    end else if (pop) begin
                        state   <= S_EMPTY;
                        if (ZERO_ON_EMPTY) main_q <= '0;
                        valid_q <= 1'b0;
                    end
                end
                S_FULL: begin
                    // Skid entry is younger; it moves up to main on pop.
                    if (pop) begin
                        state   <= S_ONE;
                        main_q  <= skid_q;
                        skid_q  <= '0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.out_data   = main_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_ready  = ready_q;
    assign out_occupancy  = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed plan plus random run.
// Reference model is a bounded FIFO queue updated once per clock edge.
module tb_pipe_stage_skid;

    localparam int W = 231;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         en = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   occ;

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    logic [W-1:0] q[$];

    pipe_stage_skid_if #(.PAYLOAD_W(W)) bus ();

    pipe_stage_skid #(.PAYLOAD_W(W), .ZERO_ON_EMPTY(1'b1)) dut (
        .in_CLK        (clk),
        .in_CLR        (clr),
        .in_EN         (en),
        .in_flush      (flush),
        .bus           (bus),
        .out_occupancy (occ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_payload();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r[W-1:0];
    endfunction

    // Compare DUT against the queue model, then apply one cycle of inputs.
    task automatic cycle(input bit c, input bit e, input bit f,
                         input bit v, input bit r, input logic [W-1:0] d);
        int  n;
        bit  mv;
        bit  mr;
        @(negedge clk);
        n = q.size();
        if (armed) begin
            check("m_valid", bus.out_valid, n > 0);
            check("m_ready", bus.out_ready, n < 2);
            check("m_occ", occ, n);
            check("m_data", bus.out_data, (n > 0) ? q[0] : '0);
            if (occ < 2) check("rdy_inv", bus.out_ready, 1);
        end
        clr = c;
        en = e;
        flush = f;
        bus.in_valid = v;
        bus.in_ready = r;
        bus.in_data = d;
        @(posedge clk);
        mv = n > 0;
        mr = n < 2;
        if (c || f) begin
            q.delete();
        end else if (e) begin
            if (mv && r) void'(q.pop_front());
            if (mr && v) q.push_back(d);
        end
        if (c) armed = 1'b1;
    endtask

    task automatic expect_out(input string tag, input bit v, input bit r,
                              input int o, input logic [W-1:0] d);
        #1;
        check({tag, "_valid"}, bus.out_valid, v);
        check({tag, "_ready"}, bus.out_ready, r);
        check({tag, "_occ"}, occ, o);
        check({tag, "_data"}, bus.out_data, d);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_ready = 1'b0;
        bus.in_data = '0;

        // Reset, two cycles
        cycle(1, 0, 0, 0, 0, '0);
        cycle(1, 0, 0, 0, 0, '0);
        expect_out("rst", 0, 1, 0, '0);

        // Stream 1,2,3,... at full rate
        for (int i = 1; i <= 5; i++) begin
            cycle(0, 1, 0, 1, 1, W'(i));
            expect_out("stream", 1, 1, 1, W'(i));
        end
        cycle(0, 1, 0, 0, 1, '0);
        expect_out("drain", 0, 1, 0, '0);

        // Backpressure then release
        cycle(0, 1, 0, 1, 0, W'(32'hA));
        expect_out("bp_a", 1, 1, 1, W'(32'hA));
        cycle(0, 1, 0, 1, 0, W'(32'hB));
        expect_out("bp_b", 1, 0, 2, W'(32'hA));
        cycle(0, 1, 0, 0, 1, '0);
        expect_out("rel_a", 1, 1, 1, W'(32'hB));
        cycle(0, 1, 0, 0, 1, '0);
        expect_out("rel_b", 0, 1, 0, '0);

        // Flush while FULL, with a concurrent accept and pop
        cycle(0, 1, 0, 1, 0, W'(32'hA));
        cycle(0, 1, 0, 1, 0, W'(32'hB));
        expect_out("pre_fl", 1, 0, 2, W'(32'hA));
        cycle(0, 1, 1, 1, 1, W'(32'hC));
        expect_out("flush", 0, 1, 0, '0);
        cycle(0, 1, 0, 0, 1, '0);
        expect_out("post_fl", 0, 1, 0, '0);

        // Freeze with ONE holding 0x55
        cycle(0, 1, 0, 1, 0, W'(32'h55));
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 1, W'(32'h66));
            expect_out("frz", 1, 1, 1, W'(32'h55));
        end
        cycle(0, 1, 0, 1, 1, W'(32'h66));
        expect_out("unfrz", 1, 1, 1, W'(32'h66));
        cycle(0, 1, 0, 0, 1, '0);

        // Reset while FULL
        cycle(0, 1, 0, 1, 0, W'(32'h11));
        cycle(0, 1, 0, 1, 0, W'(32'h22));
        cycle(1, 1, 0, 1, 1, W'(32'h33));
        expect_out("rst_mid", 0, 1, 0, '0);
        cycle(0, 1, 0, 1, 0, W'(32'h77));
        expect_out("post_rst", 1, 1, 1, W'(32'h77));

        // Random traffic against the queue model
        for (int i = 0; i < 10000; i++) begin
            bit c;
            bit e;
            bit f;
            bit v;
            bit r;
            c = ($urandom_range(0, 499) == 0);
            f = ($urandom_range(0, 29) == 0);
            e = ($urandom_range(0, 7) != 0);
            v = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) != 0);
            cycle(c, e, f, v, r, rnd_payload());
        end
        cycle(0, 1, 0, 0, 1, '0);
        cycle(0, 1, 0, 0, 1, '0);
        cycle(0, 0, 0, 0, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage registers (IF/ID … MEM/WB).
- Carries one opaque payload vector between two pipeline stages using a valid/ready handshake.
- Contains a 2-entry skid buffer, so the upstream ready is registered and the stage still sustains 1 transfer per cycle.
- Adds synchronous flush (branch/exception squash) and a global enable/freeze. Instantiated once per stage boundary.

Parameters:
- PAYLOAD_W, 231: payload width in bits; the default is six 32-bit words + three 5-bit register indices + 23-bit control + lock bit.
- ZERO_ON_EMPTY, 1: when 1, out_data is driven all-zero whenever out_valid=0 (bubble = NOP); when 0, out_data holds its last value.

Ports:
- in_CLK  input  1  clock; all state updates on the rising edge.
- in_CLR  input  1  reset, synchronous, active-high.
- in_EN  input  1  global enable; 0 freezes all state and blocks both handshakes.
- in_flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream has a payload on in_data.
- out_ready  output  1  stage can accept; registered, depends only on state.
- in_data  input  PAYLOAD_W  upstream payload.
- out_valid  output  1  out_data holds a valid payload.
- in_ready  input  1  downstream accepts this cycle.
- out_data  output  PAYLOAD_W  head payload.
- out_occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Reset (in_CLR=1 at a clock edge), dominant over everything:
  - state EMPTY; main and skid registers = 0.
  - out_valid=0, out_ready=1, out_occupancy=0, out_data=0.
- Handshake events:
  - acc = in_valid & out_ready & in_EN.
  - pop = out_valid & in_ready & in_EN.
- State encoding (out_occupancy equals this value):
  - EMPTY=0, ONE=1, FULL=2.
  - out_valid = (state!=EMPTY); out_ready = (state!=FULL).
- Transitions (apply only when in_CLR=0, in_flush=0, in_EN=1):
  - EMPTY & acc → ONE; main<=in_data.
  - ONE & acc & pop → ONE; main<=in_data.
  - ONE & acc & !pop → FULL; skid<=in_data.
  - ONE & !acc & pop → EMPTY; main<=0.
  - FULL & pop → ONE; main<=skid, skid<=0. (acc is impossible in FULL.)
  - Every other combination: hold.
- Latency and throughput:
  - A payload accepted at edge N is visible on out_data after edge N.
  - Steady-state throughput is 1 transfer/cycle with in_ready held at 1.
- Ordering: strict FIFO; main is always the older entry.
- Flush (in_flush=1, in_CLR=0):
  - Next state EMPTY; main and skid <= 0, regardless of in_EN.
  - An acc or pop in the same cycle is discarded. Upstream must treat a flush cycle as not accepted, even if out_ready=1.
- Freeze (in_EN=0, no flush/reset): all registers hold, and out_valid/out_ready keep their values. No transfer is counted even if in_valid/in_ready are high.
- Priority order: in_CLR > in_flush > in_EN > handshake.
- ZERO_ON_EMPTY=1: out_data = 0 whenever state=EMPTY. This is guaranteed by clearing main, not by an output mux.
- out_data is combinationally driven from the main register only; no in_data→out_data combinational path.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding constants ST_EMPTY/ST_ONE/ST_FULL.
  - payload field offsets/widths (word width 32, regidx width 5, control width 23) used by the stages to pack and unpack PAYLOAD_W.
- Single module; no sub-module. The two registers and the 3-state control are small enough to keep flat.

Test Plan:
- Reset then stream: CLR high 2 cycles, then in_valid=1 with data 1,2,3,… and in_ready=1 → out_data 1,2,3 one cycle later each; occupancy stays 1; out_ready stays 1.
- Backpressure: send A=0xA, B=0xB with in_ready=0 → occupancy 1 then 2; out_ready=0 after B; out_data=0xA. Raise in_ready → A, then B in order; occupancy 2→1→0; out_data=0 afterwards.
- Flush while FULL with in_valid=1 (C) and in_ready=1 → next cycle out_valid=0, occupancy 0, out_data=0; C is never emitted.
- Freeze: state ONE holding 0x55, in_EN=0 for 3 cycles with in_valid=in_ready=1 → out_data=0x55, occupancy 1 throughout; the transfer resumes the cycle after in_EN=1.
- Reset mid-operation: FULL, then CLR together with in_flush=0 and in_EN=1 → next cycle all outputs are at reset values; the first subsequent accept lands in main.
- Random valid/ready/EN/flush for 10k cycles against a scoreboard queue → FIFO order preserved, no loss except on flush, and out_ready never 0 when occupancy<2.
